game_clock_ctrl: RTL and testbench



---
 rtl/scoreboard_pkg.sv | 11 +
 rtl/game_clock_ctrl_buzz_timer.sv | 18 +
 rtl/game_clock_ctrl.sv | 89 ++++++++
 tb/tb_game_clock_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared game-clock states, digit widths and match-limit helper
package scoreboard_pkg;
  typedef enum logic [2:0] {IDLE, RUNNING, PAUSED, PERIOD_END, GAME_OVER} gc_state_t;
  localparam int SEC_W = 4;
  localparam int DEC_W = 3;
  localparam int MIN_W = 4;
  localparam int PERIOD_W = 3;
  function automatic logic [MIN_W-1:0] limit_of(input logic ot, input int per_min, input int ot_min);
    return ot ? MIN_W'(ot_min) : MIN_W'(per_min);
  endfunction
endpackage

// File: rtl/game_clock_ctrl_buzz_timer.sv
// buzz_timer: loadable down-counter whose done marks the last of CYCLES enabled cycles
module buzz_timer #(
  parameter int CYCLES = 50
) (
  input  logic clk_gc,
  input  logic rst_gc,
  input  logic start,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_gc)
    if (!rst_gc) cnt <= '0;
    else if (start) cnt <= W'(CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign done = en && cnt == '0;
endmodule

// File: rtl/game_clock_ctrl.sv
// game_clock_ctrl: button/period-end game flow FSM; GAME_CLOCK_OVERTIME_EN adds one overtime period
module game_clock_ctrl
  import scoreboard_pkg::*;
#(
  parameter int PERIOD_MIN  = 9,
  parameter int NUM_PERIODS = 4,
  parameter int BUZZ_CYCLES = 50,
  parameter int OT_MIN      = 5
) (
  input  logic                clk_gc,
  input  logic                rst_gc,
  input  logic                start_btn,
  input  logic                stop_btn,
  input  logic                clr_btn,
  input  logic [SEC_W-1:0]    sec_digit,
  input  logic [DEC_W-1:0]    dec_digit,
  input  logic [MIN_W-1:0]    min_digit,
  output logic                run_en,
  output logic                tm_clr,
  output logic [PERIOD_W-1:0] period,
  output logic                buzzer,
  output logic                game_over
);
  gc_state_t state, state_n;
  logic [PERIOD_W-1:0] period_n;
  logic tm_clr_n, ot, match, done;
`ifdef GAME_CLOCK_OVERTIME_EN
  localparam logic [PERIOD_W-1:0] LAST_P = PERIOD_W'(NUM_PERIODS);
  assign ot = period == PERIOD_W'(NUM_PERIODS);
`else
  localparam logic [PERIOD_W-1:0] LAST_P = PERIOD_W'(NUM_PERIODS - 1);
  assign ot = 1'b0;
`endif
  assign match = state == RUNNING && min_digit == limit_of(ot, PERIOD_MIN, OT_MIN)
                 && dec_digit == '0 && sec_digit == '0;
  buzz_timer #(.CYCLES(BUZZ_CYCLES)) u_buzz (
    .clk_gc (clk_gc),
    .rst_gc (rst_gc),
    .start  (state != PERIOD_END && state_n == PERIOD_END),
    .en     (state == PERIOD_END),
    .done   (done)
  );
  always_comb begin
    state_n  = state;
    period_n = period;
    tm_clr_n = 1'b0;
    case (state)
      IDLE: begin
        tm_clr_n = clr_btn;
        state_n  = !clr_btn && start_btn ? RUNNING : IDLE;
      end
      RUNNING: begin
        tm_clr_n = clr_btn;
        state_n  = clr_btn ? IDLE : match ? PERIOD_END : stop_btn ? PAUSED : RUNNING;
      end
      PAUSED: begin
        tm_clr_n = clr_btn;
        state_n  = clr_btn ? IDLE : start_btn ? RUNNING : PAUSED;
      end
      PERIOD_END: if (done) begin
        state_n  = period == LAST_P ? GAME_OVER : IDLE;
        period_n = period == LAST_P ? period : period + PERIOD_W'(1);
        tm_clr_n = period != LAST_P;
      end
      GAME_OVER: if (clr_btn) begin
        state_n  = IDLE;
        period_n = '0;
        tm_clr_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_gc)
    if (!rst_gc) begin
      state     <= IDLE;
      period    <= '0;
      tm_clr    <= 1'b0;
      run_en    <= 1'b0;
      buzzer    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      period    <= period_n;
      tm_clr    <= tm_clr_n;
      run_en    <= state_n == RUNNING;
      buzzer    <= state_n == PERIOD_END;
      game_over <= state_n == GAME_OVER;
    end
endmodule

// File: tb/tb_game_clock_ctrl.sv
// tb_game_clock_ctrl: directed vector table plus randomized run against a behavioural game model
module tb_game_clock_ctrl;
  localparam int PM = 1, NP = 2, BC = 5, OM = 2;
`ifdef GAME_CLOCK_OVERTIME_EN
  localparam bit OT = 1'b1;
`else
  localparam bit OT = 1'b0;
`endif
  logic clk_gc = 1'b0, rst_gc = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, clr_btn = 1'b0;
  logic [3:0] sec_digit = '0, min_digit = '0;
  logic [2:0] dec_digit = '0, period;
  logic run_en, tm_clr, buzzer, game_over;
  always #5 clk_gc = ~clk_gc;
  game_clock_ctrl #(.PERIOD_MIN(PM), .NUM_PERIODS(NP), .BUZZ_CYCLES(BC), .OT_MIN(OM)) dut (
    .clk_gc(clk_gc), .rst_gc(rst_gc), .start_btn(start_btn), .stop_btn(stop_btn),
    .clr_btn(clr_btn), .sec_digit(sec_digit), .dec_digit(dec_digit), .min_digit(min_digit),
    .run_en(run_en), .tm_clr(tm_clr), .period(period), .buzzer(buzzer), .game_over(game_over)
  );
  typedef struct {
    logic r, st, sp, cl;
    logic [3:0] m;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];
  int tests = 0, fails = 0;
  // model: mode 0 idle, 1 running, 2 paused, 3 buzzing, 4 game over
  int mode = 0, per = 0, left = 0;
  bit clr_pulse = 0;
  function automatic logic [6:0] e(bit run, bit clr, int p, bit bz, bit ov);
    return {run, clr, 3'(p), bz, ov};
  endfunction
  function automatic logic [6:0] model_exp();
    return e(mode == 1, clr_pulse, per, mode == 3, mode == 4);
  endfunction
  task automatic model_edge(bit r, bit st, bit sp, bit cl, int m, int d, int s);
    int lim;
    lim = (OT && per == NP) ? OM : PM;
    clr_pulse = 0;
    if (!r) begin
      mode = 0; per = 0; left = 0;
      return;
    end
    case (mode)
      0: if (cl) clr_pulse = 1; else if (st) mode = 1;
      1: if (cl) begin clr_pulse = 1; mode = 0; end
         else if (m == lim && d == 0 && s == 0) begin mode = 3; left = BC; end
         else if (sp) mode = 2;
      2: if (cl) begin clr_pulse = 1; mode = 0; end else if (st) mode = 1;
      3: begin
        left--;
        if (left == 0) begin
          if (per == (OT ? NP : NP - 1)) mode = 4;
          else begin per++; clr_pulse = 1; mode = 0; end
        end
      end
      default: if (cl) begin per = 0; clr_pulse = 1; mode = 0; end
    endcase
  endtask
  task automatic check(string name, logic [6:0] want);
    logic [6:0] got;
    got = {run_en, tm_clr, period, buzzer, game_over};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got run/clr/per/buzz/over=%b_%b_%0d_%b_%b required %b_%b_%0d_%b_%b",
               name, $time, got[6], got[5], got[4:2], got[1], got[0],
               want[6], want[5], want[4:2], want[1], want[0]);
    end
  endtask
  task automatic step(bit r, bit st, bit sp, bit cl, int m, int d, int s);
    rst_gc = r; start_btn = st; stop_btn = sp; clr_btn = cl;
    min_digit = 4'(m); dec_digit = 3'(d); sec_digit = 4'(s);
    @(posedge clk_gc);
    model_edge(r, st, sp, cl, m, d, s);
    @(negedge clk_gc);
    check("model", model_exp());
  endtask
  task automatic add(bit r, bit st, bit sp, bit cl, int m, logic [6:0] x);
    vec_t v;
    v.r = r; v.st = st; v.sp = sp; v.cl = cl; v.m = 4'(m); v.exp = x;
    tbl.push_back(v);
  endtask
  initial begin
    add(0,0,0,0,0, e(0,0,0,0,0));
    add(0,0,0,0,0, e(0,0,0,0,0));
    add(1,0,0,0,0, e(0,0,0,0,0));
    add(1,1,0,0,0, e(1,0,0,0,0));
    add(1,1,1,0,0, e(0,0,0,0,0));
    add(1,0,1,0,0, e(0,0,0,0,0));
    add(1,0,0,1,0, e(0,1,0,0,0));
    add(1,0,0,0,0, e(0,0,0,0,0));
    add(1,1,0,0,0, e(1,0,0,0,0));
    add(1,1,0,0,0, e(1,0,0,0,0));
    add(1,0,1,0,1, e(0,0,0,1,0));
    for (int i = 0; i < 4; i++) add(1,i == 1,i == 2,i == 3,1, e(0,0,0,1,0));
    add(1,0,0,0,0, e(0,1,1,0,0));
    add(1,0,0,0,0, e(0,0,1,0,0));
    add(1,1,0,0,0, e(1,0,1,0,0));
    add(1,0,0,0,1, e(0,0,1,1,0));
    for (int i = 0; i < 4; i++) add(1,0,0,0,1, e(0,0,1,1,0));
    if (OT) begin
      add(1,0,0,0,0, e(0,1,2,0,0));
      add(1,1,0,0,0, e(1,0,2,0,0));
      add(1,0,0,0,1, e(1,0,2,0,0));
      add(1,0,0,0,2, e(0,0,2,1,0));
      for (int i = 0; i < 4; i++) add(1,0,0,0,2, e(0,0,2,1,0));
      add(1,0,0,0,0, e(0,0,2,0,1));
    end else add(1,0,0,0,0, e(0,0,1,0,1));
    add(1,1,1,0,0, e(0,0,OT ? 2 : 1,0,1));
    add(1,0,0,1,0, e(0,1,0,0,0));
    add(1,0,0,0,0, e(0,0,0,0,0));
    add(1,1,0,0,0, e(1,0,0,0,0));
    add(1,0,0,0,1, e(0,0,0,1,0));
    add(1,0,0,0,1, e(0,0,0,1,0));
    add(1,0,0,0,1, e(0,0,0,1,0));
    add(0,0,0,0,1, e(0,0,0,0,0));
    add(1,0,0,0,0, e(0,0,0,0,0));
    add(1,1,0,1,0, e(0,1,0,0,0));
    @(negedge clk_gc);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].m, 0, 0);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    for (int i = 0; i < 3000; i++) begin
      int m, d, s;
      if ($urandom_range(3) == 0) begin
        m = $urandom_range(1, 2); d = 0; s = 0;
      end else begin
        m = $urandom_range(9); d = $urandom_range(5); s = $urandom_range(9);
      end
      step($urandom_range(63) != 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
           $urandom_range(9) == 0, m, d, s);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
